instr_fetch_unit: RTL and testbench

- Instruction-fetch front end of the single-cycle/multicycle CPU datapath.
- Holds the program counter and a writable instruction memory, and presents the fetched 16-bit instruction word.
- Steers the instruction's register-specifier fields through two register-address muxes that feed the register file read ports RA1 and RA2.
- Includes a local clock-enable gate so fetch can be stalled.

---
 rtl/instr_fetch_unit.sv | 54 +++++
 tb/tb_instr_fetch_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: program counter, writable instruction memory,
// fetched-instruction register and the register-address muxes for RA1/RA2.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PC_RESET = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              en,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        RegSrc,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] RD,
  output logic              rd_valid,
  output logic [3:0]        RA1,
  output logic [2:0]        RA2
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Program loading; the array has no reset so contents survive RST_N.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Fetch pipeline stage; reading mem here with the write above gives read-first behaviour.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PC       <= ADDR_W'(PC_RESET);
      RD       <= '0;
      rd_valid <= 1'b0;
    end else if (en) begin
      RD       <= mem[PC];
      rd_valid <= 1'b1;
      PC       <= pc_load ? pc_in : PC + ADDR_W'(1);
    end
  end

  // Register-specifier steering; RA1 select 1 addresses R15 (the PC register).
  always_comb begin
    RA1 = RegSrc[0] ? 4'd15 : {1'b0, RD[11:9]};
    RA2 = RegSrc[1] ? RD[8:6] : RD[5:3];
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RST_N;
  logic        en;
  logic        pc_load;
  logic [3:0]  pc_in;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  RegSrc;
  logic [3:0]  PC;
  logic [15:0] RD;
  logic        rd_valid;
  logic [3:0]  RA1;
  logic [2:0]  RA2;

  int passed;
  int total;
  logic [15:0] model [16];

  instr_fetch_unit #(.ADDR_W(4), .DATA_W(16), .PC_RESET(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .en(en), .pc_load(pc_load), .pc_in(pc_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .RegSrc(RegSrc),
    .PC(PC), .RD(RD), .rd_valid(rd_valid), .RA1(RA1), .RA2(RA2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; en = 1'b0; pc_load = 1'b0; pc_in = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; RegSrc = 2'b00;
    step();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = model[i];
      step();
    end
    wr_en = 1'b0;
    step();
    total++; if (PC !== 4'd0) $display("FAIL reset_pc: got %0d want 0", PC); else passed++;
    total++; if (RD !== 16'h0) $display("FAIL reset_rd: got %h want 0000", RD); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rd_valid); else passed++;
    RST_N = 1'b1; en = 1'b1;
    step();
    total++; if (RD !== 16'h0E28) $display("FAIL first_fetch_rd: got %h want 0e28", RD); else passed++;
    total++; if (PC !== 4'd1) $display("FAIL first_fetch_pc: got %0d want 1", PC); else passed++;
    total++; if (rd_valid !== 1'b1) $display("FAIL first_fetch_valid: got %b want 1", rd_valid); else passed++;
  endtask

  task automatic test_sequential();
    logic [15:0] exp_rd [4];
    exp_rd[0] = 16'h0E28; exp_rd[1] = 16'h1234; exp_rd[2] = 16'hA5C7; exp_rd[3] = 16'hFFFF;
    RST_N = 1'b0; #1; RST_N = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (RD !== exp_rd[i]) $display("FAIL seq_rd[%0d]: got %h want %h", i, RD, exp_rd[i]); else passed++;
      total++; if (PC !== 4'(i + 1)) $display("FAIL seq_pc[%0d]: got %0d want %0d", i, PC, i + 1); else passed++;
    end
  endtask

  task automatic test_mux();
    logic [3:0] exp_ra1 [4];
    logic [2:0] exp_ra2 [4];
    exp_ra1[0] = 4'd7;  exp_ra2[0] = 3'd5;
    exp_ra1[1] = 4'd15; exp_ra2[1] = 3'd5;
    exp_ra1[2] = 4'd7;  exp_ra2[2] = 3'd0;
    exp_ra1[3] = 4'd15; exp_ra2[3] = 3'd0;
    RST_N = 1'b0; #1; RST_N = 1'b1; en = 1'b1;
    step();
    en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      RegSrc = 2'(s);
      #1;
      total++; if (RA1 !== exp_ra1[s]) $display("FAIL mux_ra1[%0d]: got %0d want %0d", s, RA1, exp_ra1[s]); else passed++;
      total++; if (RA2 !== exp_ra2[s]) $display("FAIL mux_ra2[%0d]: got %0d want %0d", s, RA2, exp_ra2[s]); else passed++;
    end
    RegSrc = 2'b00;
  endtask

  task automatic test_stall_branch();
    en = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd10; wr_data = 16'hC0DE;
    step();
    wr_en = 1'b0;
    model[10] = 16'hC0DE;
    for (int i = 0; i < 2; i++) step();
    total++; if (PC !== 4'd1) $display("FAIL stall_pc: got %0d want 1", PC); else passed++;
    total++; if (RD !== 16'h0E28) $display("FAIL stall_rd: got %h want 0e28", RD); else passed++;
    en = 1'b1; pc_load = 1'b1; pc_in = 4'd9;
    step();
    pc_load = 1'b0;
    total++; if (PC !== 4'd9) $display("FAIL branch_pc: got %0d want 9", PC); else passed++;
    total++; if (RD !== 16'h1234) $display("FAIL branch_rd: got %h want 1234", RD); else passed++;
    step();
    total++; if (RD !== model[9]) $display("FAIL branch_target_rd: got %h want %h", RD, model[9]); else passed++;
    total++; if (PC !== 4'd10) $display("FAIL branch_target_pc: got %0d want 10", PC); else passed++;
    step();
    total++; if (RD !== 16'hC0DE) $display("FAIL stall_write_rd: got %h want c0de", RD); else passed++;
  endtask

  task automatic test_wrap_read_first();
    en = 1'b1; pc_load = 1'b1; pc_in = 4'd15;
    step();
    pc_load = 1'b0;
    total++; if (PC !== 4'd15) $display("FAIL wrap_load_pc: got %0d want 15", PC); else passed++;
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'h5A5A;
    step();
    wr_en = 1'b0;
    total++; if (PC !== 4'd0) $display("FAIL wrap_pc: got %0d want 0", PC); else passed++;
    total++; if (RD !== 16'hB00F) $display("FAIL read_first_old: got %h want b00f", RD); else passed++;
    pc_load = 1'b1; pc_in = 4'd15;
    step();
    pc_load = 1'b0;
    total++; if (RD !== 16'h0E28) $display("FAIL wrap_fetch0_rd: got %h want 0e28", RD); else passed++;
    step();
    total++; if (RD !== 16'h5A5A) $display("FAIL read_first_new: got %h want 5a5a", RD); else passed++;
    total++; if (PC !== 4'd0) $display("FAIL wrap_again_pc: got %0d want 0", PC); else passed++;
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    step();
    step();
    total++; if (PC !== 4'd2) $display("FAIL pre_reset_pc: got %0d want 2", PC); else passed++;
    #2;
    RST_N = 1'b0;
    #1;
    total++; if (PC !== 4'd0) $display("FAIL async_pc: got %0d want 0", PC); else passed++;
    total++; if (RD !== 16'h0) $display("FAIL async_rd: got %h want 0000", RD); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL async_valid: got %b want 0", rd_valid); else passed++;
    step();
    RST_N = 1'b1;
    step();
    total++; if (RD !== 16'h0E28) $display("FAIL post_reset_rd: got %h want 0e28", RD); else passed++;
    total++; if (PC !== 4'd1) $display("FAIL post_reset_pc: got %0d want 1", PC); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    model[0] = 16'h0E28; model[1] = 16'h1234; model[2] = 16'hA5C7; model[3] = 16'hFFFF;
    for (int i = 4; i < 16; i++) model[i] = 16'hB000 + 16'(i);
    test_reset();
    test_sequential();
    test_mux();
    test_stall_branch();
    test_wrap_read_first();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
